// File: rtl/data_mem_responder.sv
// Load/store responder for the memory stage: valid/ready request, fixed-latency response pulse.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int D_WIDTH   = 32,
  parameter int ADDR_BITS = 17,
  parameter int LATENCY   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_uns,
  input  logic [D_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [D_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               busy
);

  localparam int IDX_W = ADDR_BITS - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, next_state;
  logic [3:0] cnt;

  logic               we_q, uns_q;
  logic [1:0]         size_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [D_WIDTH-1:0] wdata_q;

  logic               accept, enter_resp, use_req, mem_we;
  logic               acc_we, acc_uns, acc_err;
  logic [1:0]         acc_size, lane;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [D_WIDTH-1:0] acc_wdata, wdata_sh, rd_word, rd_sh, load_data;
  logic [3:0]         be;
  logic [IDX_W-1:0]   widx;

  logic [D_WIDTH-1:0] rdata_q;
  logic               err_q;

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic unused_bits;
  assign unused_bits = &{1'b0, req_addr[D_WIDTH-1:ADDR_BITS], rd_sh[D_WIDTH-1:16]};

  assign req_ready  = (state != WAIT);
  assign busy       = (state == WAIT);
  assign accept     = req_valid && req_ready;
  assign enter_resp = (next_state == RESP);
  assign rsp_valid  = (state == RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = rsp_valid && err_q;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = (LATENCY > 1) ? WAIT : RESP;
      WAIT: if (cnt == 4'd1) next_state = RESP;
      RESP: begin
        next_state = IDLE;
        if (req_valid) next_state = (LATENCY > 1) ? WAIT : RESP;
      end
      default: next_state = IDLE;
    endcase
  end

  // With LATENCY==1 the access completes on its accepting edge, so it must use the live request.
  assign use_req   = (state != WAIT);
  assign acc_we    = use_req ? req_we    : we_q;
  assign acc_uns   = use_req ? req_uns   : uns_q;
  assign acc_size  = use_req ? req_size  : size_q;
  assign acc_addr  = use_req ? req_addr[ADDR_BITS-1:0] : addr_q;
  assign acc_wdata = use_req ? req_wdata : wdata_q;
  assign widx      = acc_addr[ADDR_BITS-1:2];

  always_comb begin
    lane = 2'b00;
    be   = 4'b1111;
    case (acc_size)
      2'b00: begin
        lane = acc_addr[1:0];
        be   = 4'b0001 << acc_addr[1:0];
      end
      2'b01: begin
        lane = {acc_addr[1], 1'b0};
        be   = 4'b0011 << {acc_addr[1], 1'b0};
      end
      default: begin
        lane = 2'b00;
        be   = 4'b1111;
      end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = (acc_size == 2'b11) ||
                   ((acc_size == 2'b01) && acc_addr[0]) ||
                   ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
  assign acc_err = 1'b0;
`endif

  assign wdata_sh = acc_wdata << {lane, 3'b000};
  assign rd_word  = mem[widx];
  assign rd_sh    = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = rd_word;
    case (acc_size)
      2'b00: load_data = acc_uns ? {{(D_WIDTH-8){1'b0}}, rd_sh[7:0]}
                                 : {{(D_WIDTH-8){rd_sh[7]}}, rd_sh[7:0]};
      2'b01: load_data = acc_uns ? {{(D_WIDTH-16){1'b0}}, rd_sh[15:0]}
                                 : {{(D_WIDTH-16){rd_sh[15]}}, rd_sh[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // The array is deliberately outside the reset domain; reset only drops the pending write.
  assign mem_we = enter_resp && acc_we && !acc_err && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_uns;
        size_q  <= req_size;
        addr_q  <= req_addr[ADDR_BITS-1:0];
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_we || acc_err) ? '0 : load_data;
      end
    end
  end

endmodule
